// File: rtl/mycpu_regfile_sb.sv
// Multi-read, dual write-back register file with per-register pending (scoreboard) bits.
// Register 0 reads as zero; optional same-cycle forwarding of write-back data to the read ports.
module mycpu_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic                         flush
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  wr0_ok;
  logic                  wr1_ok;

  assign wr0_ok = wen0 && (waddr0 != '0);
  assign wr1_ok = wen1 && (waddr1 != '0);

  // Entry 0 is never written after reset, so both regs[0] and pending[0] stay zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      pending <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr1_ok && waddr1 == ADDR_WIDTH'(r)) begin
          regs[r] <= wdata1;
        end else if (wr0_ok && waddr0 == ADDR_WIDTH'(r)) begin
          regs[r] <= wdata0;
        end

        // A new producer issued in the same cycle as an older write-back keeps the bit set.
        if (flush) begin
          pending[r] <= 1'b0;
        end else if (iss_en && iss_addr == ADDR_WIDTH'(r)) begin
          pending[r] <= 1'b1;
        end else if ((wr0_ok && waddr0 == ADDR_WIDTH'(r)) ||
                     (wr1_ok && waddr1 == ADDR_WIDTH'(r))) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

  // Outputs are forced to zero while reset is held, so forwarding cannot leak write data.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_WIDTH-1:0] ra;
      logic                  hit0;
      logic                  hit1;
      ra   = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      hit0 = (BYPASS != 0) && wr0_ok && (waddr0 == ra);
      hit1 = (BYPASS != 0) && wr1_ok && (waddr1 == ra);
      if (rst && ra != '0) begin
        if (hit1) begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata1;
        end else if (hit0) begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata0;
        end else begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
        end
        rbusy[k] = pending[ra] & ~(hit0 | hit1);
      end
    end
  end

endmodule
